// File: rtl/pcs_am_pkg.sv
// Shared PCS alignment-marker definitions: lane marker table, sync header and the BIP3 parity function.
// The RX BIP checker reuses the same function.
package pcs_am_pkg;

   localparam int AM_LANE_N = 4;
   localparam logic [1:0] AM_SYNC = 2'b01;

   typedef logic [7:0] am_byte_t;
   typedef am_byte_t am_m_t [AM_LANE_N][3];

   localparam am_m_t AM_M = '{
      '{8'h90, 8'h76, 8'h47},
      '{8'hF0, 8'hC4, 8'hE6},
      '{8'hC5, 8'h65, 8'h9B},
      '{8'hA2, 8'h79, 8'h3D}
   };

   // Bit k folds bit k of every payload byte; the two sync bits land on bits 3 and 4.
   function automatic logic [7:0] bip3(input logic [65:0] b);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            acc[k] = acc[k] ^ b[2 + k + 8*n];
         end
      end
      acc[3] = acc[3] ^ b[0];
      acc[4] = acc[4] ^ b[1];
      return acc;
   endfunction

endpackage

// File: rtl/am_bip_acc.sv
// Running BIP3 accumulator over the blocks placed on the lane output.
// seed_v restarts the accumulation from the parity of the block being sent (the new AM).
module am_bip_acc
   import pcs_am_pkg::*;
#(
   parameter int BLOCK_W = 66
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               seed_v,
   input  logic [BLOCK_W-1:0] blk,
   output logic [7:0]         bip_o
);

   logic [7:0] bip_q;
   logic [7:0] bip_d;

   always_comb begin
      bip_d = seed_v ? bip3(blk) : (bip_q ^ bip3(blk));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bip_q <= 8'h00;
      end else begin
         bip_q <= bip_d;
      end
   end

   assign bip_o = bip_q;

endmodule

// File: rtl/am_insert_lane_tx.sv
// Per-lane TX alignment-marker insertion: stalls upstream once per period and emits a
// lane-specific 66b AM carrying BIP3/BIP7 over every block sent since the previous AM.
module am_insert_lane_tx
   import pcs_am_pkg::*;
#(
   parameter int BLOCK_W   = 66,
   parameter int LANE      = 0,
   parameter int AM_PERIOD = 16383,
   parameter int CNT_W     = $clog2(AM_PERIOD + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BLOCK_W-1:0] data_i,
   output logic               ready_o,
   output logic [BLOCK_W-1:0] data_o,
   output logic               am_v_o
);

   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [7:0]         bip_q;
   logic               am_slot;
   logic [BLOCK_W-1:0] am_blk;
   logic [BLOCK_W-1:0] out_d;

   // Slot 0 of every period is reserved for the AM; slots 1..AM_PERIOD carry data.
   assign am_slot = (cnt_q == '0);
   assign ready_o = ~reset & ~am_slot;

   always_comb begin
      cnt_d = (cnt_q == CNT_W'(AM_PERIOD)) ? '0 : cnt_q + CNT_W'(1);
   end

   assign am_blk = {~bip_q, ~AM_M[LANE][2], ~AM_M[LANE][1], ~AM_M[LANE][0],
                    bip_q,  AM_M[LANE][2],  AM_M[LANE][1],  AM_M[LANE][0], AM_SYNC};

   assign out_d = am_slot ? am_blk : data_i;

   am_bip_acc #(
      .BLOCK_W(BLOCK_W)
   ) u_bip (
      .clk   (clk),
      .reset (reset),
      .seed_v(am_slot),
      .blk   (out_d),
      .bip_o (bip_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         data_o <= '0;
         am_v_o <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         data_o <= out_d;
         am_v_o <= am_slot;
      end
   end

endmodule

// File: tb/tb_am_insert_lane_tx.sv
// Bench for am_insert_lane_tx: lanes 0 and 3 side by side, directed scenarios then a random run,
// all cross-checked every cycle against a stream-level model of the AM/data schedule and BIP.
module tb_am_insert_lane_tx;

   localparam int P = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [65:0] data_i = '0;
   logic        ready0, ready3, am0, am3;
   logic [65:0] dout0, dout3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   am_insert_lane_tx #(.BLOCK_W(66), .LANE(0), .AM_PERIOD(P)) dut0 (
      .clk(clk), .reset(reset), .data_i(data_i),
      .ready_o(ready0), .data_o(dout0), .am_v_o(am0));

   am_insert_lane_tx #(.BLOCK_W(66), .LANE(3), .AM_PERIOD(P)) dut3 (
      .clk(clk), .reset(reset), .data_i(data_i),
      .ready_o(ready3), .data_o(dout3), .am_v_o(am3));

   function automatic logic [7:0] m_bip3(input logic [65:0] b);
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 2; j < 66; j++) acc[(j - 2) % 8] = acc[(j - 2) % 8] ^ b[j];
      acc[3] = acc[3] ^ b[0];
      acc[4] = acc[4] ^ b[1];
      return acc;
   endfunction

   function automatic logic [65:0] m_am(input int lane, input logic [7:0] bip);
      logic [7:0] m [3];
      logic [7:0] by [8];
      logic [65:0] r;
      case (lane)
         0:       m = '{8'h90, 8'h76, 8'h47};
         1:       m = '{8'hF0, 8'hC4, 8'hE6};
         2:       m = '{8'hC5, 8'h65, 8'h9B};
         default: m = '{8'hA2, 8'h79, 8'h3D};
      endcase
      by = '{m[0], m[1], m[2], bip, ~m[0], ~m[1], ~m[2], ~bip};
      r = '0;
      r[1:0] = 2'b01;
      for (int i = 0; i < 8; i++) r[2 + 8*i +: 8] = by[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream model: after reset release, every (P+1)th block is an AM, the rest echo data_i.
   bit          known = 0;
   int          t = 0;
   logic [7:0]  bip_m = 8'h00;
   logic [65:0] exp0 = '0, exp3 = '0;
   logic        exp_am = 1'b0;
   logic        exp_rdy;

   always @(negedge clk) begin
      if (known) begin
         exp_rdy = !reset && ((t % (P + 1)) != 0);
         chk("data_o lane0", dout0, exp0);
         chk("data_o lane3", dout3, exp3);
         chk("am_v_o lane0", 66'(am0), 66'(exp_am));
         chk("am_v_o lane3", 66'(am3), 66'(exp_am));
         chk("ready_o lane0", 66'(ready0), 66'(exp_rdy));
         chk("ready_o lane3", 66'(ready3), 66'(exp_rdy));
      end
      if (reset) begin
         known = 1;
         t = 0;
         bip_m = 8'h00;
         exp0 = '0;
         exp3 = '0;
         exp_am = 1'b0;
      end else if (known) begin
         if ((t % (P + 1)) == 0) begin
            exp0 = m_am(0, bip_m);
            exp3 = m_am(3, bip_m);
            exp_am = 1'b1;
            bip_m = m_bip3(exp0);
         end else begin
            exp0 = data_i;
            exp3 = data_i;
            exp_am = 1'b0;
            bip_m = bip_m ^ m_bip3(data_i);
         end
         t++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [65:0] d1, d2, d3, ones;
   logic [95:0] rnd;

   initial begin
      d1   = 66'h1_0123_4567_89AB_CDEF;
      d2   = 66'h2_FEDC_BA98_7654_3210;
      d3   = 66'h0_5555_AAAA_0F0F_F0F0;
      ones = 66'h3_FFFF_FFFF_FFFF_FFFF;

      chk("model bip3 all-ones", 66'(m_bip3(ones)), 66'h18);

      reset = 1'b1;
      tick;
      tick;
      chk("reset data_o", dout0, '0);
      chk("reset am_v_o", 66'(am0), 66'h0);
      chk("reset ready_o", 66'(ready0), 66'h0);

      // cycle 0 after release: AM slot, input is a stall value
      reset = 1'b0;
      data_i = 66'hA5;
      #1;
      chk("cycle0 ready_o", 66'(ready0), 66'h0);
      tick;
      chk("cycle1 am_v_o", 66'(am0), 66'h1);
      chk("cycle1 AM lane0", dout0,
          {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01});
      chk("cycle1 AM lane3", dout3,
          {8'hFF, 8'hC2, 8'h86, 8'h5D, 8'h00, 8'h3D, 8'h79, 8'hA2, 2'b01});
      chk("cycle1 ready_o", 66'(ready0), 66'h1);
      data_i = d1;
      tick;
      chk("cycle2 D1", dout0, d1);
      data_i = d2;
      tick;
      chk("cycle3 D2", dout0, d2);
      data_i = d3;
      tick;
      chk("cycle4 D3", dout0, d3);
      chk("cycle4 ready_o", 66'(ready0), 66'h0);
      data_i = 66'hA5;
      tick;
      chk("cycle5 am_v_o", 66'(am0), 66'h1);
      chk("stalled A5 not passed", 66'(dout0 == 66'hA5), 66'h0);

      // one period of all-ones data: BIP3 = 08 (AM seed) ^ 18
      for (int i = 0; i < P; i++) begin
         data_i = ones;
         tick;
      end
      data_i = 66'hA5;
      tick;
      chk("all-ones AM am_v_o", 66'(am0), 66'h1);
      chk("all-ones AM BIP3", 66'(dout0[33:26]), 66'h10);
      chk("all-ones AM BIP7", 66'(dout0[65:58]), 66'hEF);
      chk("all-ones AM lane3 BIP3", 66'(dout3[33:26]), 66'h10);

      // reset two blocks into a period
      data_i = d1;
      tick;
      data_i = d2;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      chk("post-reset am_v_o", 66'(am0), 66'h1);
      chk("post-reset BIP3", 66'(dout0[33:26]), 66'h00);
      chk("post-reset BIP7", 66'(dout0[65:58]), 66'hFF);

      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom(), $urandom(), $urandom()};
         data_i = rnd[65:0];
         reset = (i == 617);
         tick;
      end
      reset = 1'b0;
      tick;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
